tick_sequencer: RTL

//   Upstream stage for the simple clocked-counter test modules: turns the free-running
//   clk into a prescaled single-cycle tick and counts ticks up to a bounded limit.
//   Its tick output drives the consumer's clock input; done marks the end of the

---
 rtl/tick_seq_pkg.sv | 15 +
 rtl/tick_sequencer_if.sv | 31 +++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/tick_sequencer.sv | 101 ++++++++++
 4 files changed

// File: rtl/tick_seq_pkg.sv
// Shared state encoding and sizing helper for the tick sequencer and its prescaler.
package tick_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // $clog2 with a floor of 1 so DIV=1 or DIV=2 still gets a real register bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/tick_sequencer_if.sv
// Control/status bundle between a test harness (master) and the tick sequencer (slave).
interface tick_sequencer_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic             halt;
  logic             tick;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output halt,
    input  tick,
    input  count,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  halt,
    output tick,
    output count,
    output busy,
    output done
  );

endinterface

// File: rtl/tick_prescaler.sv
// Modulo-DIV counter; wrap strobes combinationally in the cycle the counter sits at DIV-1.
module tick_prescaler
  import tick_seq_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  localparam int unsigned PW = clog2_min1(DIV);
  localparam logic [PW-1:0] Last = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == Last);
  assign wrap    = enable && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = at_last ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_sequencer.sv
// Prescaled single-cycle tick generator with a bounded, restartable tick count.
module tick_sequencer
  import tick_seq_pkg::*;
#(
  parameter int unsigned DIV   = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LIMIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  tick_sequencer_if.slave  bus
);

  localparam bit               Bounded = (LIMIT != 0);
  localparam logic [WIDTH-1:0] LimitW  = WIDTH'(LIMIT);

  state_e           state_q, state_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] count_inc;
  logic             pre_clear, pre_en, pre_wrap;

  // Prescaler rests at zero outside RUN, so every run starts on a fresh phase.
  // A same-edge halt freezes it, which also suppresses that edge's tick.
  assign pre_clear = (state_q != S_RUN);
  assign pre_en    = (state_q == S_RUN) && !bus.halt;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (pre_clear),
    .enable (pre_en),
    .wrap   (pre_wrap)
  );

  assign count_inc = count_q + WIDTH'(1);

  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.halt) begin
          state_d = S_RUN;
          count_d = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.halt) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (pre_wrap) begin
          tick_d  = 1'b1;
          count_d = count_inc;
          if (Bounded && (count_inc == LimitW)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tick  = tick_q;
  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
